stream_axis2fifo: RTL

Write-side adapter for the byte-stream datapath: accepts a narrow valid/ready stream, packs IDSIZE-byte beats into ODSIZE-byte words, and drives a FIFO-style write port (write-enable + not-full flag) through a small skid buffer. It is the mirror of the FIFO-to-stream read adapter. It sits in front of the sync/async FIFOs on the host-to-device path so that no combinational path runs from downstream full to upstream ready.

---
 rtl/stream_axis2fifo.sv | 131 +++++++++++++
 1 files changed

// File: rtl/stream_axis2fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stream_axis2fifo                                             |
// | Description : Packs narrow valid/ready beats into wide words and drives a  |
// |               FIFO write port through a registered-ready skid buffer.      |
// |               Optional packet support: STREAM_AXIS2FIFO_TLAST_EN.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stream_axis2fifo #(
  parameter int IDSIZE = 1,
  parameter int ODSIZE = 4,
  parameter int SASIZE = 1
) (
  input  logic                rst_n,
  input  logic                iclk,
  input  logic                itvalid,
  output logic                itready,
  input  logic [IDSIZE*8-1:0] itdata,
`ifdef STREAM_AXIS2FIFO_TLAST_EN
  input  logic                itlast,
`endif
  output logic                o_wen,
  output logic [ODSIZE*8-1:0] o_wdata,
  output logic [ODSIZE-1:0]   o_wkeep,
`ifdef STREAM_AXIS2FIFO_TLAST_EN
  output logic                o_wlast,
`endif
  input  logic                i_fulln
);

  localparam int c_R  = ODSIZE / IDSIZE;
  localparam int c_D  = 1 << SASIZE;
  localparam int c_IW = IDSIZE * 8;
  localparam int c_OW = ODSIZE * 8;
  localparam int c_XW = (c_R > 1) ? $clog2(c_R) : 1;

  logic [c_XW-1:0]   r_idx;
  logic [c_OW-1:0]   r_part;
  logic              r_itready;
  logic              w_accept;
  logic              w_last_in;
  logic              w_done;
  logic              w_pop;
  logic [c_OW-1:0]   w_push_data;
  logic [ODSIZE-1:0] w_push_keep;

  logic [c_OW-1:0]   r_mem_data [c_D];
  logic [ODSIZE-1:0] r_mem_keep [c_D];
  logic [c_D-1:0]    r_mem_last;
  logic [SASIZE-1:0] r_wptr;
  logic [SASIZE-1:0] r_rptr;
  logic [SASIZE:0]   r_count;
  logic [SASIZE:0]   w_count_next;

`ifdef STREAM_AXIS2FIFO_TLAST_EN
  assign w_last_in = itlast;
`else
  assign w_last_in = 1'b0;
`endif

  assign itready  = r_itready;
  assign w_accept = itvalid & r_itready;
  assign w_done   = w_accept & ((r_idx == c_XW'(c_R - 1)) | w_last_in);

  // Merge the incoming beat into its lane; keep covers lanes 0..idx.
  always_comb begin
    w_push_data = r_part;
    w_push_keep = '0;
    for (int l = 0; l < c_R; l++) begin
      if (l == int'(r_idx)) w_push_data[l*c_IW +: c_IW] = itdata;
`ifdef STREAM_AXIS2FIFO_TLAST_EN
      if (l <= int'(r_idx)) w_push_keep[l*IDSIZE +: IDSIZE] = '1;
`endif
    end
`ifndef STREAM_AXIS2FIFO_TLAST_EN
    w_push_keep = '1;
`endif
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_part <= '0;
    end else if (w_accept) begin
      if (w_done) begin
        r_idx  <= '0;
        r_part <= '0;
      end else begin
        r_idx  <= r_idx + c_XW'(1);
        r_part <= w_push_data;
      end
    end
  end

  assign w_pop        = (r_count != '0) & i_fulln;
  assign w_count_next = r_count + (SASIZE+1)'(w_done) - (SASIZE+1)'(w_pop);

  // Ready is registered from the next occupancy, so a push always has room.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      r_itready <= 1'b0;
      r_count   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_mem_last <= '0;
      for (int e = 0; e < c_D; e++) begin
        r_mem_data[e] <= '0;
        r_mem_keep[e] <= '0;
      end
    end else begin
      r_itready <= (w_count_next < (SASIZE+1)'(c_D));
      r_count   <= w_count_next;
      if (w_done) begin
        r_mem_data[r_wptr] <= w_push_data;
        r_mem_keep[r_wptr] <= w_push_keep;
        r_mem_last[r_wptr] <= w_last_in;
        r_wptr             <= r_wptr + SASIZE'(1);
      end
      if (w_pop) r_rptr <= r_rptr + SASIZE'(1);
    end
  end

  assign o_wen   = w_pop;
  assign o_wdata = r_mem_data[r_rptr];
  assign o_wkeep = r_mem_keep[r_rptr];
`ifdef STREAM_AXIS2FIFO_TLAST_EN
  assign o_wlast = r_mem_last[r_rptr];
`endif

endmodule
`default_nettype wire
